// File: rtl/video_mode_ctrl.sv
// Video mode sequencer for pixel_counters: holds the three-mode timing table, brings timing up and switches modes at frame boundaries.
// Optional watchdog on WAIT_FS/MUTE stalls is enabled by defining VIDEO_MODE_CTRL_WDOG_EN (adds the wdog_trip output).
module video_mode_ctrl #(
   parameter int SETTLE_CYCLES = 16,
   parameter int MUTE_FRAMES   = 2
) (
   input  logic        pixel_clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        mode_req,
   input  logic [1:0]  mode_sel,
   input  logic        frame_start,
   output logic        mode_ack,
   output logic        mode_err,
   output logic [11:0] h_total,
   output logic [11:0] v_total,
   output logic [11:0] h_sync,
   output logic [11:0] v_sync,
   output logic        ctr_rst_n,
   output logic        video_en,
   output logic [1:0]  cur_mode,
   output logic        busy
`ifdef VIDEO_MODE_CTRL_WDOG_EN
   ,
   output logic        wdog_trip
`endif
);

   typedef enum logic [2:0] {
      S_OFF,
      S_HOLD,
      S_MUTE,
      S_RUN,
      S_WAIT_FS
   } state_t;

   typedef struct packed {
      logic [11:0] h_total;
      logic [11:0] v_total;
      logic [11:0] h_sync;
      logic [11:0] v_sync;
   } timing_t;

   localparam logic [7:0] SETTLE_LD    = 8'(SETTLE_CYCLES);
   localparam logic [4:0] MUTE_N       = 5'(MUTE_FRAMES);
   localparam logic [1:0] MODE_INVALID = 2'd3;

   function automatic timing_t mode_timing(input logic [1:0] m);
      timing_t t;
      case (m)
         2'd1:    t = {12'd858,  12'd525,  12'd62, 12'd6};
         2'd2:    t = {12'd2200, 12'd1125, 12'd44, 12'd5};
         default: t = {12'd1650, 12'd750,  12'd40, 12'd5};
      endcase
      return t;
   endfunction

   state_t     state;
   timing_t    tim;
   logic [1:0] pend_mode;
   logic [7:0] settle_cnt;
   logic [4:0] mute_cnt;

`ifdef VIDEO_MODE_CTRL_WDOG_EN
   localparam logic [23:0] WDOG_MAX = 24'hFF_FFFF;
   logic [23:0] wdog_cnt;
`endif

   assign h_total = tim.h_total;
   assign v_total = tim.v_total;
   assign h_sync  = tim.h_sync;
   assign v_sync  = tim.v_sync;

   always_ff @(posedge pixel_clk or posedge rst) begin
      if (rst) begin
         state      <= S_OFF;
         tim        <= mode_timing(2'd0);
         cur_mode   <= 2'd0;
         pend_mode  <= 2'd0;
         settle_cnt <= '0;
         mute_cnt   <= '0;
         ctr_rst_n  <= 1'b0;
         video_en   <= 1'b0;
         mode_ack   <= 1'b0;
         mode_err   <= 1'b0;
         busy       <= 1'b0;
`ifdef VIDEO_MODE_CTRL_WDOG_EN
         wdog_cnt   <= '0;
         wdog_trip  <= 1'b0;
`endif
      end else begin
         mode_ack <= 1'b0;
         mode_err <= 1'b0;
`ifdef VIDEO_MODE_CTRL_WDOG_EN
         wdog_trip <= 1'b0;
         wdog_cnt  <= '0;
`endif
         // Dropping enable wins over every other event; the pending mode is simply forgotten.
         if (state != S_OFF && !enable) begin
            state     <= S_OFF;
            ctr_rst_n <= 1'b0;
            video_en  <= 1'b0;
            busy      <= 1'b0;
         end else begin
            case (state)
               S_OFF: begin
                  if (mode_req) begin
                     if (mode_sel == MODE_INVALID) begin
                        mode_err <= 1'b1;
                     end else begin
                        cur_mode <= mode_sel;
                        tim      <= mode_timing(mode_sel);
                        mode_ack <= 1'b1;
                     end
                  end
                  if (enable) begin
                     state      <= S_HOLD;
                     settle_cnt <= SETTLE_LD;
                     busy       <= 1'b1;
                  end
               end

               S_HOLD: begin
                  if (settle_cnt <= 8'd1) begin
                     ctr_rst_n <= 1'b1;
                     busy      <= 1'b0;
                     mute_cnt  <= '0;
                     if (MUTE_N == 5'd0) begin
                        state    <= S_RUN;
                        video_en <= 1'b1;
                     end else begin
                        state <= S_MUTE;
                     end
                  end else begin
                     settle_cnt <= settle_cnt - 8'd1;
                  end
               end

               S_MUTE, S_RUN: begin
                  if (mode_req && mode_sel != MODE_INVALID) begin
                     pend_mode <= mode_sel;
                     mode_ack  <= 1'b1;
                     video_en  <= 1'b0;
                     busy      <= 1'b1;
                     state     <= S_WAIT_FS;
                  end else begin
                     if (mode_req) mode_err <= 1'b1;
                     if (state == S_MUTE) begin
                        if (frame_start) begin
                           if (mute_cnt + 5'd1 == MUTE_N) begin
                              state    <= S_RUN;
                              video_en <= 1'b1;
                           end else begin
                              mute_cnt <= mute_cnt + 5'd1;
                           end
                        end
`ifdef VIDEO_MODE_CTRL_WDOG_EN
                        else if (wdog_cnt == WDOG_MAX) begin
                           state      <= S_HOLD;
                           settle_cnt <= SETTLE_LD;
                           ctr_rst_n  <= 1'b0;
                           busy       <= 1'b1;
                           wdog_trip  <= 1'b1;
                        end else begin
                           wdog_cnt <= wdog_cnt + 24'd1;
                        end
`endif
                     end
                  end
               end

               S_WAIT_FS: begin
                  // New timing is loaded only on the edge that also asserts counter reset.
                  if (frame_start) begin
                     state      <= S_HOLD;
                     cur_mode   <= pend_mode;
                     tim        <= mode_timing(pend_mode);
                     ctr_rst_n  <= 1'b0;
                     settle_cnt <= SETTLE_LD;
                  end
`ifdef VIDEO_MODE_CTRL_WDOG_EN
                  else if (wdog_cnt == WDOG_MAX) begin
                     state      <= S_HOLD;
                     cur_mode   <= pend_mode;
                     tim        <= mode_timing(pend_mode);
                     ctr_rst_n  <= 1'b0;
                     settle_cnt <= SETTLE_LD;
                     wdog_trip  <= 1'b1;
                  end else begin
                     wdog_cnt <= wdog_cnt + 24'd1;
                  end
`endif
               end

               default: begin
                  state     <= S_OFF;
                  ctr_rst_n <= 1'b0;
                  video_en  <= 1'b0;
                  busy      <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Bench for video_mode_ctrl: two configurations (16/2 and 1/0) driven in parallel, checked every cycle against a behavioural model.
module tb_video_mode_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       mode_req = 1'b0;
   logic [1:0] mode_sel = 2'd0;
   logic       frame_start = 1'b0;

   logic        mode_ack_w[2], mode_err_w[2], ctr_rst_n_w[2], video_en_w[2], busy_w[2];
   logic [11:0] h_total_w[2], v_total_w[2], h_sync_w[2], v_sync_w[2];
   logic [1:0]  cur_mode_w[2];

   int total = 0;
   int bad   = 0;

   video_mode_ctrl #(.SETTLE_CYCLES(16), .MUTE_FRAMES(2)) dut0 (
      .pixel_clk(clk), .rst(rst), .enable(enable), .mode_req(mode_req), .mode_sel(mode_sel),
      .frame_start(frame_start), .mode_ack(mode_ack_w[0]), .mode_err(mode_err_w[0]),
      .h_total(h_total_w[0]), .v_total(v_total_w[0]), .h_sync(h_sync_w[0]), .v_sync(v_sync_w[0]),
      .ctr_rst_n(ctr_rst_n_w[0]), .video_en(video_en_w[0]), .cur_mode(cur_mode_w[0]), .busy(busy_w[0])
   );

   video_mode_ctrl #(.SETTLE_CYCLES(1), .MUTE_FRAMES(0)) dut1 (
      .pixel_clk(clk), .rst(rst), .enable(enable), .mode_req(mode_req), .mode_sel(mode_sel),
      .frame_start(frame_start), .mode_ack(mode_ack_w[1]), .mode_err(mode_err_w[1]),
      .h_total(h_total_w[1]), .v_total(v_total_w[1]), .h_sync(h_sync_w[1]), .v_sync(v_sync_w[1]),
      .ctr_rst_n(ctr_rst_n_w[1]), .video_en(video_en_w[1]), .cur_mode(cur_mode_w[1]), .busy(busy_w[1])
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Mode table as plain numbers: index by mode.
   int ht_tab[3] = '{1650, 858, 2200};
   int vt_tab[3] = '{750, 525, 1125};
   int hs_tab[3] = '{40, 62, 44};
   int vs_tab[3] = '{5, 6, 5};

   function automatic int settle_of(input int i);
      return (i == 0) ? 16 : 1;
   endfunction

   function automatic int mute_of(input int i);
      return (i == 0) ? 2 : 0;
   endfunction

   // Model: "on" = timing enabled, hold_left = counter reset cycles remaining,
   // waiting = switch accepted and waiting for a frame boundary, ven = video shown.
   int m_on[2], m_hold[2], m_wait[2], m_frames[2], m_pend[2], m_ven[2], m_cur[2], m_ack[2], m_err[2];

   task automatic model_step(input int i);
      m_ack[i] = 0;
      m_err[i] = 0;
      if (m_on[i] == 0) begin
         if (mode_req) begin
            if (mode_sel == 2'd3) m_err[i] = 1;
            else begin
               m_cur[i] = int'(mode_sel);
               m_ack[i] = 1;
            end
         end
         if (enable) begin
            m_on[i]   = 1;
            m_hold[i] = settle_of(i);
         end
      end else if (!enable) begin
         m_on[i] = 0; m_hold[i] = 0; m_wait[i] = 0; m_ven[i] = 0; m_frames[i] = 0;
      end else if (m_hold[i] > 0) begin
         m_hold[i]--;
         if (m_hold[i] == 0) begin
            m_frames[i] = 0;
            if (mute_of(i) == 0) m_ven[i] = 1;
         end
      end else if (m_wait[i] != 0) begin
         if (frame_start) begin
            m_wait[i] = 0;
            m_cur[i]  = m_pend[i];
            m_hold[i] = settle_of(i);
         end
      end else begin
         if (mode_req && mode_sel != 2'd3) begin
            m_pend[i] = int'(mode_sel);
            m_ack[i]  = 1;
            m_ven[i]  = 0;
            m_wait[i] = 1;
         end else begin
            if (mode_req) m_err[i] = 1;
            if (m_ven[i] == 0 && frame_start) begin
               m_frames[i]++;
               if (m_frames[i] == mute_of(i)) m_ven[i] = 1;
            end
         end
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            m_on[i] = 0; m_hold[i] = 0; m_wait[i] = 0; m_frames[i] = 0; m_pend[i] = 0;
            m_ven[i] = 0; m_cur[i] = 0; m_ack[i] = 0; m_err[i] = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) model_step(i);
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         check_val($sformatf("d%0d.mode_ack", i), int'(mode_ack_w[i]), m_ack[i]);
         check_val($sformatf("d%0d.mode_err", i), int'(mode_err_w[i]), m_err[i]);
         check_val($sformatf("d%0d.cur_mode", i), int'(cur_mode_w[i]), m_cur[i]);
         check_val($sformatf("d%0d.h_total", i), int'(h_total_w[i]), ht_tab[m_cur[i]]);
         check_val($sformatf("d%0d.v_total", i), int'(v_total_w[i]), vt_tab[m_cur[i]]);
         check_val($sformatf("d%0d.h_sync", i), int'(h_sync_w[i]), hs_tab[m_cur[i]]);
         check_val($sformatf("d%0d.v_sync", i), int'(v_sync_w[i]), vs_tab[m_cur[i]]);
         check_val($sformatf("d%0d.ctr_rst_n", i), int'(ctr_rst_n_w[i]),
                   (m_on[i] != 0 && m_hold[i] == 0) ? 1 : 0);
         check_val($sformatf("d%0d.video_en", i), int'(video_en_w[i]), m_ven[i]);
         check_val($sformatf("d%0d.busy", i), int'(busy_w[i]),
                   (m_wait[i] != 0 || m_hold[i] > 0) ? 1 : 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_fs();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   initial begin
      int low0, low1, errs, acks, ven_drop, n, req_left;

      rst = 1'b1;
      repeat (3) tick();
      check_val("rst.h_total", int'(h_total_w[0]), 1650);
      check_val("rst.ctr_rst_n", int'(ctr_rst_n_w[0]), 0);
      check_val("rst.video_en", int'(video_en_w[0]), 0);
      check_val("rst.cur_mode", int'(cur_mode_w[0]), 0);
      rst = 1'b0;
      tick();

      // Bring-up: count cycles the counters are held in reset.
      enable = 1'b1;
      tick();
      low0 = 0;
      low1 = 0;
      for (int c = 0; c < 40; c++) begin
         if (!ctr_rst_n_w[0]) low0++;
         if (!ctr_rst_n_w[1]) low1++;
         tick();
      end
      check_val("up.settle0", low0, 16);
      check_val("up.settle1", low1, 1);
      check_val("up.ven1", int'(video_en_w[1]), 1);
      check_val("up.ven0_pre", int'(video_en_w[0]), 0);
      pulse_fs();
      check_val("up.ven0_fs1", int'(video_en_w[0]), 0);
      pulse_fs();
      check_val("up.ven0_fs2", int'(video_en_w[0]), 1);
      check_val("up.h_total", int'(h_total_w[0]), 1650);
      check_val("up.v_total", int'(v_total_w[0]), 750);

      // Switch to 1920x1080.
      mode_req = 1'b1;
      mode_sel = 2'd2;
      tick();
      mode_req = 1'b0;
      check_val("sw.ack", int'(mode_ack_w[0]), 1);
      check_val("sw.ven", int'(video_en_w[0]), 0);
      check_val("sw.busy", int'(busy_w[0]), 1);
      check_val("sw.h_total_held", int'(h_total_w[0]), 1650);
      tick();
      check_val("sw.ack_once", int'(mode_ack_w[0]), 0);
      pulse_fs();
      check_val("sw.h_total", int'(h_total_w[0]), 2200);
      check_val("sw.v_total", int'(v_total_w[0]), 1125);
      check_val("sw.h_sync", int'(h_sync_w[0]), 44);
      check_val("sw.cur_mode", int'(cur_mode_w[0]), 2);
      check_val("sw.ctr_rst_n", int'(ctr_rst_n_w[0]), 0);
      repeat (20) tick();
      pulse_fs();
      pulse_fs();
      check_val("sw.run_ven", int'(video_en_w[0]), 1);

      // Invalid mode held three cycles.
      mode_req = 1'b1;
      mode_sel = 2'd3;
      errs = 0; acks = 0; ven_drop = 0;
      repeat (3) begin
         tick();
         errs += int'(mode_err_w[0]);
         acks += int'(mode_ack_w[0]);
         if (!video_en_w[0]) ven_drop++;
      end
      mode_req = 1'b0;
      tick();
      errs += int'(mode_err_w[0]);
      check_val("inv.errs", errs, 3);
      check_val("inv.acks", acks, 0);
      check_val("inv.ven_drop", ven_drop, 0);

      // Request held across WAIT_FS and HOLD is served once counters are released.
      mode_req = 1'b1;
      mode_sel = 2'd0;
      tick();
      check_val("held.first_ack", int'(mode_ack_w[0]), 1);
      mode_sel = 2'd1;
      tick();
      check_val("held.wait_ack", int'(mode_ack_w[0]), 0);
      pulse_fs();
      check_val("held.applied", int'(cur_mode_w[0]), 0);
      acks = 0;
      n = 0;
      while (!ctr_rst_n_w[0] && n < 40) begin
         tick();
         acks += int'(mode_ack_w[0]);
         n++;
      end
      check_val("held.hold_acks", acks, 0);
      check_val("held.released", int'(ctr_rst_n_w[0]), 1);
      tick();
      check_val("held.mute_ack", int'(mode_ack_w[0]), 1);
      check_val("held.busy", int'(busy_w[0]), 1);
      mode_req = 1'b0;
      tick();

      // enable drop coincident with frame_start while waiting.
      enable = 1'b0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check_val("off.cur_mode", int'(cur_mode_w[0]), 0);
      check_val("off.h_total", int'(h_total_w[0]), 1650);
      check_val("off.ctr_rst_n", int'(ctr_rst_n_w[0]), 0);
      check_val("off.ack", int'(mode_ack_w[0]), 0);
      check_val("off.busy", int'(busy_w[0]), 0);
      repeat (3) tick();
      enable = 1'b1;

      // Randomized traffic; the per-cycle model comparison does the checking.
      req_left = 0;
      for (int c = 0; c < 6000; c++) begin
         if ($urandom_range(0, 1999) == 0) begin
            #2 rst = 1'b1;
            tick();
            rst = 1'b0;
         end
         frame_start = ($urandom_range(0, 11) == 0);
         if (req_left > 0) begin
            req_left--;
         end else if ($urandom_range(0, 39) == 0) begin
            mode_req = 1'b1;
            mode_sel = 2'($urandom_range(0, 3));
            req_left = int'($urandom_range(1, 30));
         end else begin
            mode_req = 1'b0;
         end
         if (!enable) enable = ($urandom_range(0, 5) == 0);
         else if ($urandom_range(0, 499) == 0) enable = 1'b0;
         tick();
      end

      mode_req = 1'b0;
      frame_start = 1'b0;
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/video_mode_ctrl.md
Name: video_mode_ctrl

Overview:
Sequencer/configurator for the pixel_counters timing generator. Holds a fixed table of three video modes and drives pixel_counters' h_total/v_total/h_sync/v_sync and its active-low reset. Brings timing up on enable and switches modes glitch-free at a frame boundary. Gates downstream video with video_en during switch and settle.

Parameters:
SETTLE_CYCLES, 16, cycles ctr_rst_n held low after loading new timing (1..255)
MUTE_FRAMES, 2, frame_start pulses seen after counter release before video_en asserts (0..15)

Ports:
pixel_clk  in  1  pixel clock
rst  in  1  asynchronous active-high reset
enable  in  1  level; 1 = timing running
mode_req  in  1  level request; held until mode_ack
mode_sel  in  2  requested mode: 0=1280x720 (1650/750, sync 40/5), 1=720x480 (858/525, sync 62/6), 2=1920x1080 (2200/1125, sync 44/5), 3=invalid
frame_start  in  1  from pixel_counters
mode_ack  out  1  one-cycle accept pulse
mode_err  out  1  one-cycle pulse, invalid mode_sel rejected
h_total  out  12  to pixel_counters
v_total  out  12  to pixel_counters
h_sync  out  12  to pixel_counters
v_sync  out  12  to pixel_counters
ctr_rst_n  out  1  to pixel_counters rst_n
video_en  out  1  1 = timing stable, video valid
cur_mode  out  2  mode currently applied
busy  out  1  1 in WAIT_FS or HOLD

Behaviour:
- All outputs registered. Reset: state OFF, cur_mode=0, timing outputs = mode 0 values, ctr_rst_n=0, video_en=0, mode_ack=0, mode_err=0, busy=0.
- States: OFF, HOLD, MUTE, RUN, WAIT_FS.
- OFF: ctr_rst_n=0, video_en=0. mode_req with valid mode_sel -> cur_mode and timing outputs updated next cycle, mode_ack pulse. enable=1 -> HOLD.
- HOLD: ctr_rst_n=0; settle counter loaded with SETTLE_CYCLES on entry; after exactly SETTLE_CYCLES cycles in HOLD -> MUTE. busy=1.
- MUTE: ctr_rst_n=1, video_en=0; counts frame_start pulses; on MUTE_FRAMES-th pulse -> RUN (MUTE_FRAMES=0: HOLD goes straight to RUN, counters released on same edge).
- RUN: ctr_rst_n=1, video_en=1.
- Request in RUN or MUTE, valid mode_sel: latch pending mode, mode_ack next cycle, video_en=0 next cycle, -> WAIT_FS. Requesting the current mode is still a full switch.
- WAIT_FS: busy=1, ctr_rst_n=1; on frame_start -> HOLD with timing outputs and cur_mode updated on that same edge.
- mode_req in WAIT_FS/HOLD: not acked; requester keeps it high; served on entry to MUTE/RUN.
- mode_sel=3 with mode_req in any accepting state: mode_err pulse, no ack, no state change; err re-pulses every cycle request stays high.
- enable=0 in any state -> OFF next cycle; pending mode discarded, cur_mode keeps last applied value; priority over frame_start and mode_req same cycle (no ack).
- Timing outputs change only in OFF or on WAIT_FS->HOLD edge; never while ctr_rst_n=1.
- rst mid-operation: immediate return to reset values.

Optional Feature:
Macro VIDEO_MODE_CTRL_WDOG_EN. With it: 24-bit watchdog counts cycles in WAIT_FS and MUTE since last frame_start/state entry; on reaching 2^24-1 -> forced HOLD (pending mode applied if in WAIT_FS), extra output wdog_trip pulses one cycle. Without it: no watchdog, no wdog_trip port; WAIT_FS waits indefinitely.

Test Plan:
- Reset, enable=1 with defaults -> ctr_rst_n low exactly 16 cycles, then video_en=1 on edge after second frame_start; h_total=1650, v_total=750.
- In RUN, mode_req mode_sel=2 -> mode_ack 1 cycle, video_en=0, busy=1; at next frame_start h_total=2200, v_total=1125, h_sync=44, cur_mode=2, ctr_rst_n low 16 cycles.
- mode_sel=3 held 3 cycles in RUN -> mode_err 3 pulses, no ack, video_en stays 1.
- Second mode_req held during WAIT_FS -> no ack until MUTE entry, then ack and new WAIT_FS.
- enable=0 on same cycle as frame_start in WAIT_FS -> OFF, cur_mode unchanged, ctr_rst_n=0, no ack.
- SETTLE_CYCLES=1, MUTE_FRAMES=0 -> ctr_rst_n low 1 cycle, video_en=1 same edge as release.
